// File: rtl/calc_dispatcher.sv
// calc_dispatcher: descriptor table plus command sequencer for the matrix calculator core.
module calc_dispatcher #(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned SLOT_STRIDE = 25,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_slot_a,
  input  logic [2:0]  cmd_slot_b,
  input  logic [2:0]  cmd_slot_res,
  input  logic [31:0] cmd_scalar,
  input  logic        desc_we,
  input  logic [2:0]  desc_slot,
  input  logic [2:0]  desc_m,
  input  logic [2:0]  desc_n,
  output logic        desc_wr_err,
  input  logic [2:0]  rd_slot,
  output logic [2:0]  rd_m,
  output logic [2:0]  rd_n,
  output logic        rd_valid,
  output logic        core_start,
  output logic [2:0]  core_op,
  output logic [7:0]  core_op1_addr,
  output logic [7:0]  core_op2_addr,
  output logic [7:0]  core_res_addr,
  output logic [31:0] core_op1_m,
  output logic [31:0] core_op1_n,
  output logic [31:0] core_op2_m,
  output logic [31:0] core_op2_n,
  input  logic        core_done,
  output logic        busy,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err
);

  localparam int unsigned SLOT_W = 3;
  localparam int unsigned DIM_W  = 3;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(5);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_WAIT, S_COMMIT, S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLOTS-1:0]    valid_q, valid_d;
  logic [DIM_W-1:0]        m_q [NUM_SLOTS];
  logic [DIM_W-1:0]        m_d [NUM_SLOTS];
  logic [DIM_W-1:0]        n_q [NUM_SLOTS];
  logic [DIM_W-1:0]        n_d [NUM_SLOTS];
  logic [2:0]              op_q, op_d;
  logic [SLOT_W-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DATA_W-1:0]       scalar_q, scalar_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    desc_wr_err_q, desc_wr_err_d;
  logic                    core_start_q, core_start_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [1:0]              rsp_err_q, rsp_err_d;
  logic [2:0]              core_op_q, core_op_d;
  logic [ADDR_W-1:0]       op1_addr_q, op1_addr_d, op2_addr_q, op2_addr_d, res_addr_q, res_addr_d;
  logic [DATA_W-1:0]       op1_m_q, op1_m_d, op1_n_q, op1_n_d, op2_m_q, op2_m_d, op2_n_q, op2_n_d;
  logic [1:0]              chk_err;
  logic                    uses_b;

  // Sequential state: FSM, descriptor table, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      m_q           <= '{default: '0};
      n_q           <= '{default: '0};
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      scalar_q      <= '0;
      cnt_q         <= '0;
      desc_wr_err_q <= 1'b0;
      core_start_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= '0;
      core_op_q     <= '0;
      op1_addr_q    <= '0;
      op2_addr_q    <= '0;
      res_addr_q    <= '0;
      op1_m_q       <= '0;
      op1_n_q       <= '0;
      op2_m_q       <= '0;
      op2_n_q       <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      m_q           <= m_d;
      n_q           <= n_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      scalar_q      <= scalar_d;
      cnt_q         <= cnt_d;
      desc_wr_err_q <= desc_wr_err_d;
      core_start_q  <= core_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      core_op_q     <= core_op_d;
      op1_addr_q    <= op1_addr_d;
      op2_addr_q    <= op2_addr_d;
      res_addr_q    <= res_addr_d;
      op1_m_q       <= op1_m_d;
      op1_n_q       <= op1_n_d;
      op2_m_q       <= op2_m_d;
      op2_n_q       <= op2_n_d;
    end
  end

  // Next-state, table updates and output computation.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    m_d           = m_q;
    n_d           = n_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    scalar_d      = scalar_q;
    cnt_d         = cnt_q;
    desc_wr_err_d = 1'b0;
    core_start_d  = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = rsp_err_q;
    core_op_d     = core_op_q;
    op1_addr_d    = op1_addr_q;
    op2_addr_d    = op2_addr_q;
    res_addr_d    = res_addr_q;
    op1_m_d       = op1_m_q;
    op1_n_d       = op1_n_q;
    op2_m_d       = op2_m_q;
    op2_n_d       = op2_n_q;
    chk_err       = 2'd0;
    uses_b        = (op_q == 3'd1) || (op_q == 3'd3);

    // Host descriptor writes land only while idle and with legal dimensions.
    if (desc_we) begin
      if ((state_q == S_IDLE) && (desc_m != '0) && (desc_m <= MAX_DIM) &&
          (desc_n != '0) && (desc_n <= MAX_DIM)) begin
        m_d[desc_slot]     = desc_m;
        n_d[desc_slot]     = desc_n;
        valid_d[desc_slot] = 1'b1;
      end else begin
        desc_wr_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          a_d      = cmd_slot_a;
          b_d      = cmd_slot_b;
          res_d    = cmd_slot_res;
          scalar_d = cmd_scalar;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_q >= 3'd4) begin
          chk_err = 2'd2;
        end else if (!valid_q[a_q] || (uses_b && !valid_q[b_q])) begin
          chk_err = 2'd1;
        end else if ((op_q == 3'd1) && ((m_q[a_q] != m_q[b_q]) || (n_q[a_q] != n_q[b_q]))) begin
          chk_err = 2'd2;
        end else if ((op_q == 3'd3) && (n_q[a_q] != m_q[b_q])) begin
          chk_err = 2'd2;
        end
        if (chk_err != 2'd0) begin
          rsp_err_d   = chk_err;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          core_start_d = 1'b1;
          core_op_d    = op_q;
          op1_addr_d   = ADDR_W'(a_q) * ADDR_W'(SLOT_STRIDE);
          res_addr_d   = ADDR_W'(res_q) * ADDR_W'(SLOT_STRIDE);
          op1_m_d      = DATA_W'(m_q[a_q]);
          op1_n_d      = DATA_W'(n_q[a_q]);
          op2_addr_d   = '0;
          op2_m_d      = '0;
          op2_n_d      = '0;
          if (uses_b) begin
            op2_addr_d = ADDR_W'(b_q) * ADDR_W'(SLOT_STRIDE);
            op2_m_d    = DATA_W'(m_q[b_q]);
            op2_n_d    = DATA_W'(n_q[b_q]);
          end else if (op_q == 3'd2) begin
            op2_m_d    = scalar_q;
          end
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the final watchdog cycle still counts as success.
        if (core_done) begin
          state_d = S_COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          valid_d[res_q] = 1'b0;
          rsp_err_d      = 2'd3;
          rsp_valid_d    = 1'b1;
          state_d        = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        // Result shape: transpose swaps, matrix multiply takes (mA, nB), others keep A.
        if (op_q == 3'd0) begin
          m_d[res_q] = n_q[a_q];
          n_d[res_q] = m_q[a_q];
        end else if (op_q == 3'd3) begin
          m_d[res_q] = m_q[a_q];
          n_d[res_q] = n_q[b_q];
        end else begin
          m_d[res_q] = m_q[a_q];
          n_d[res_q] = n_q[a_q];
        end
        valid_d[res_q] = 1'b1;
        rsp_err_d      = 2'd0;
        rsp_valid_d    = 1'b1;
        state_d        = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign rd_m          = m_q[rd_slot];
  assign rd_n          = n_q[rd_slot];
  assign rd_valid      = valid_q[rd_slot];
  assign desc_wr_err   = desc_wr_err_q;
  assign core_start    = core_start_q;
  assign core_op       = core_op_q;
  assign core_op1_addr = op1_addr_q;
  assign core_op2_addr = op2_addr_q;
  assign core_res_addr = res_addr_q;
  assign core_op1_m    = op1_m_q;
  assign core_op1_n    = op1_n_q;
  assign core_op2_m    = op2_m_q;
  assign core_op2_n    = op2_n_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_calc_dispatcher.sv
// Directed self-checking bench for calc_dispatcher.
module tb_calc_dispatcher;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op, cmd_slot_a, cmd_slot_b, cmd_slot_res;
  logic [31:0] cmd_scalar;
  logic        desc_we;
  logic [2:0]  desc_slot, desc_m, desc_n;
  logic        desc_wr_err;
  logic [2:0]  rd_slot, rd_m, rd_n;
  logic        rd_valid;
  logic        core_start;
  logic [2:0]  core_op;
  logic [7:0]  core_op1_addr, core_op2_addr, core_res_addr;
  logic [31:0] core_op1_m, core_op1_n, core_op2_m, core_op2_n;
  logic        core_done, busy, rsp_valid;
  logic [1:0]  rsp_err;

  int checks = 0;
  int failures = 0;

  calc_dispatcher dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_slot_a(cmd_slot_a), .cmd_slot_b(cmd_slot_b), .cmd_slot_res(cmd_slot_res),
    .cmd_scalar(cmd_scalar),
    .desc_we(desc_we), .desc_slot(desc_slot), .desc_m(desc_m), .desc_n(desc_n),
    .desc_wr_err(desc_wr_err),
    .rd_slot(rd_slot), .rd_m(rd_m), .rd_n(rd_n), .rd_valid(rd_valid),
    .core_start(core_start), .core_op(core_op),
    .core_op1_addr(core_op1_addr), .core_op2_addr(core_op2_addr), .core_res_addr(core_res_addr),
    .core_op1_m(core_op1_m), .core_op1_n(core_op1_n),
    .core_op2_m(core_op2_m), .core_op2_n(core_op2_n),
    .core_done(core_done), .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [2:0] slot,
                          input logic [2:0] em, input logic [2:0] en, input logic ev);
    rd_slot = slot;
    #1;
    check({tag, "_valid"}, 32'(rd_valid), 32'(ev));
    check({tag, "_m"}, 32'(rd_m), 32'(em));
    check({tag, "_n"}, 32'(rd_n), 32'(en));
  endtask

  task automatic desc_write(input logic [2:0] slot, input logic [2:0] m, input logic [2:0] n);
    desc_we = 1'b1; desc_slot = slot; desc_m = m; desc_n = n;
    tick();
    desc_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] res, input logic [31:0] scalar);
    cmd_valid = 1'b1; cmd_op = op; cmd_slot_a = a; cmd_slot_b = b;
    cmd_slot_res = res; cmd_scalar = scalar;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_slot_a = '0; cmd_slot_b = '0;
    cmd_slot_res = '0; cmd_scalar = '0; desc_we = 1'b0; desc_slot = '0; desc_m = '0;
    desc_n = '0; rd_slot = '0; core_done = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_desc_wr_err", 32'(desc_wr_err), 32'd0);
    check("rst_op1_addr", 32'(core_op1_addr), 32'd0);
    check("rst_op2_m", core_op2_m, 32'd0);
    rd_check("rst_rd0", 3'd0, 3'd0, 3'd0, 1'b0);

    // Descriptor writes: slot0 2x3, slot1 3x2
    desc_write(3'd0, 3'd2, 3'd3);
    check("wr0_err", 32'(desc_wr_err), 32'd0);
    rd_check("wr0_rd", 3'd0, 3'd2, 3'd3, 1'b1);
    desc_write(3'd1, 3'd3, 3'd2);
    rd_check("wr1_rd", 3'd1, 3'd3, 3'd2, 1'b1);

    // Matrix multiply 0 x 1 -> 2
    issue(3'd3, 3'd0, 3'd1, 3'd2, 32'd0);
    check("mm_check_ready", 32'(cmd_ready), 32'd0);
    check("mm_check_busy", 32'(busy), 32'd1);
    check("mm_check_start", 32'(core_start), 32'd0);
    tick();
    check("mm_start", 32'(core_start), 32'd1);
    check("mm_op", 32'(core_op), 32'd3);
    check("mm_op1_addr", 32'(core_op1_addr), 32'd0);
    check("mm_op2_addr", 32'(core_op2_addr), 32'd25);
    check("mm_res_addr", 32'(core_res_addr), 32'd50);
    check("mm_op1_m", core_op1_m, 32'd2);
    check("mm_op1_n", core_op1_n, 32'd3);
    check("mm_op2_m", core_op2_m, 32'd3);
    check("mm_op2_n", core_op2_n, 32'd2);
    tick();
    check("mm_wait_start", 32'(core_start), 32'd0);
    tick(); tick(); tick();
    check("mm_wait_rsp", 32'(rsp_valid), 32'd0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("mm_commit_rsp", 32'(rsp_valid), 32'd0);
    check("mm_commit_addr_stable", 32'(core_op2_addr), 32'd25);
    tick();
    check("mm_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mm_rsp_err", 32'(rsp_err), 32'd0);
    rd_check("mm_rd2", 3'd2, 3'd2, 3'd2, 1'b1);
    tick();
    check("mm_idle_rsp", 32'(rsp_valid), 32'd0);
    check("mm_idle_ready", 32'(cmd_ready), 32'd1);

    // Add with mismatched shapes -> err 2 two cycles after handshake
    issue(3'd1, 3'd0, 3'd1, 3'd3, 32'd0);
    check("add_chk_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_rsp_err", 32'(rsp_err), 32'd2);
    check("add_no_start", 32'(core_start), 32'd0);
    rd_check("add_rd3", 3'd3, 3'd0, 3'd0, 1'b0);
    rd_check("add_rd0", 3'd0, 3'd2, 3'd3, 1'b1);
    tick();

    // Illegal op -> err 2
    issue(3'd5, 3'd0, 3'd1, 3'd3, 32'd0);
    tick();
    check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ill_rsp_err", 32'(rsp_err), 32'd2);
    tick();

    // Transpose of empty slot 4 -> err 1
    issue(3'd0, 3'd4, 3'd0, 3'd5, 32'd0);
    tick();
    check("empty_rsp_valid", 32'(rsp_valid), 32'd1);
    check("empty_rsp_err", 32'(rsp_err), 32'd1);
    tick();

    // Out-of-range descriptor write rejected
    desc_write(3'd5, 3'd6, 3'd2);
    check("badwr_err", 32'(desc_wr_err), 32'd1);
    rd_check("badwr_rd5", 3'd5, 3'd0, 3'd0, 1'b0);
    tick();
    check("badwr_err_pulse", 32'(desc_wr_err), 32'd0);

    // Scalar multiply with withheld done -> timeout; slot6 preloaded so invalidation is visible
    desc_write(3'd6, 3'd1, 3'd1);
    issue(3'd2, 3'd0, 3'd1, 3'd6, 32'd7);
    tick();
    check("sm_start", 32'(core_start), 32'd1);
    check("sm_op2_m", core_op2_m, 32'd7);
    check("sm_op2_n", core_op2_n, 32'd0);
    check("sm_op2_addr", 32'(core_op2_addr), 32'd0);
    check("sm_res_addr", 32'(core_res_addr), 32'd150);
    tick();
    // Write attempted while busy is rejected
    desc_write(3'd7, 3'd2, 3'd2);
    check("busywr_err", 32'(desc_wr_err), 32'd1);
    for (int i = 0; i < 4093; i++) tick();
    check("sm_last_wait_busy", 32'(busy), 32'd1);
    check("sm_last_wait_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("sm_to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("sm_to_rsp_err", 32'(rsp_err), 32'd3);
    rd_check("sm_to_rd6", 3'd6, 3'd1, 3'd1, 1'b0);
    rd_check("busywr_rd7", 3'd7, 3'd0, 3'd0, 1'b0);
    tick();

    // Done arriving in the exact timeout cycle wins: op2 on slot1 3x2 -> slot7
    issue(3'd2, 3'd1, 3'd0, 3'd7, 32'd3);
    tick();
    check("edge_op1_addr", 32'(core_op1_addr), 32'd25);
    check("edge_res_addr", 32'(core_res_addr), 32'd175);
    tick();
    for (int i = 0; i < 4094; i++) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("edge_commit_rsp", 32'(rsp_valid), 32'd0);
    check("edge_commit_busy", 32'(busy), 32'd1);
    tick();
    check("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    check("edge_rsp_err", 32'(rsp_err), 32'd0);
    rd_check("edge_rd7", 3'd7, 3'd3, 3'd2, 1'b1);
    tick();

    // Same-cycle write + command: CHECK sees slot3 = 4x1; transpose in place
    desc_we = 1'b1; desc_slot = 3'd3; desc_m = 3'd4; desc_n = 3'd1;
    issue(3'd0, 3'd3, 3'd5, 3'd3, 32'd9);
    desc_we = 1'b0;
    tick();
    check("tr_start", 32'(core_start), 32'd1);
    check("tr_op1_m", core_op1_m, 32'd4);
    check("tr_op1_n", core_op1_n, 32'd1);
    check("tr_op2_m", core_op2_m, 32'd0);
    check("tr_op1_addr", 32'(core_op1_addr), 32'd75);
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    check("tr_rsp_err", 32'(rsp_err), 32'd0);
    rd_check("tr_rd3", 3'd3, 3'd1, 3'd4, 1'b1);
    tick();

    // Reset while in WAIT
    issue(3'd0, 3'd0, 3'd0, 3'd4, 32'd0);
    tick(); tick(); tick();
    check("rstw_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_ready", 32'(cmd_ready), 32'd1);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_rsp", 32'(rsp_valid), 32'd0);
    rd_check("rstw_rd0", 3'd0, 3'd0, 3'd0, 1'b0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("rstw_late_done_busy", 32'(busy), 32'd0);
    check("rstw_late_done_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("rstw_late_done_rsp2", 32'(rsp_valid), 32'd0);
    rd_check("rstw_rd4", 3'd4, 3'd0, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_dispatcher.md
# calc_dispatcher

Command front-end for the matrix calculator core. It holds a descriptor table of 8 matrix slots in storage, each with a base address, dimensions and a valid flag. It accepts one operation command at a time over a valid/ready handshake and validates operand dimensions before the datapath is touched. It then sequences the core (start pulse, wait for done, with a watchdog) and commits the result descriptor. It sits between the top-level UI FSM and the calculator core, replacing the direct FSM-to-core parameter wiring.

## Interface
- NUM_SLOTS, 8: matrix slots; slot s has fixed base address s*SLOT_STRIDE.
- SLOT_STRIDE, 25: words per slot, sized for a 5x5 maximum; NUM_SLOTS*SLOT_STRIDE must be ≤ 256.
- TIMEOUT, 4095: maximum cycles spent in WAIT before the watchdog error.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command transfers on cmd_valid & cmd_ready.
- cmd_op  in  3  0 transpose, 1 add, 2 scalar multiply, 3 matrix multiply; 4-7 illegal.
- cmd_slot_a / cmd_slot_b / cmd_slot_res  in  3 each  operand A, operand B and result slots.
- cmd_scalar  in  32  scalar for op 2.
- desc_we  in  1  descriptor write strobe; honoured only in IDLE.
- desc_slot  in  3  slot being written.
- desc_m / desc_n  in  3 each  dimensions being written.
- desc_wr_err  out  1  one-cycle pulse when a descriptor write is rejected.
- rd_slot  in  3  combinational read-port slot select.
- rd_m / rd_n  out  3 each  dimensions of rd_slot.
- rd_valid  out  1  valid flag of rd_slot.
- core_start  out  1  one-cycle start pulse to the core.
- core_op  out  3  op code to the core.
- core_op1_addr / core_op2_addr / core_res_addr  out  8 each  base addresses to the core.
- core_op1_m / core_op1_n / core_op2_m / core_op2_n  out  32 each  operand dimensions to the core.
- core_done  in  1  completion pulse from the core.
- busy  out  1  high whenever the state is not IDLE.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  2  response code, valid with rsp_valid: 0 ok, 1 empty operand, 2 illegal op or dimension mismatch, 3 timeout.

## Operation
- **Descriptor writes**
  - A write is accepted when desc_we is high in IDLE and desc_m, desc_n are both in 1..5; the slot's m and n are set and valid becomes 1.
  - A write is rejected (desc_wr_err pulses, table unchanged) if either dimension is 0 or greater than 5, or if desc_we is high while busy.
  - If desc_we and a command handshake fall in the same IDLE cycle, the write is applied first; CHECK sees the updated table.
- **States:** IDLE → CHECK → (START → WAIT → COMMIT | error) → RESP → IDLE.
- **IDLE:** cmd_ready=1. On handshake, latch op, the three slots and the scalar; go to CHECK.
- **CHECK (1 cycle)** evaluates, in this priority order:
  - op ≥ 4 → err 2.
  - A invalid, or B invalid for op 1/3 → err 1.
  - op 1 with (mA≠mB or nA≠nB) → err 2.
  - op 3 with nA≠mB → err 2.
  - On any error go to RESP with the table untouched; otherwise go to START.
- **START (1 cycle):** core_start=1. core_* outputs are driven from the latched command and stay stable from START through COMMIT.
  - op1_addr=A*SLOT_STRIDE, op1_m=mA, op1_n=nA.
  - For ops 1 and 3: op2_addr=B*SLOT_STRIDE, op2_m=mB, op2_n=nB.
  - For op 2: op2_m=cmd_scalar, op2_n=0, op2_addr=0.
  - For op 0: all op2 fields are 0.
  - res_addr=res*SLOT_STRIDE.
  - All dimensions are zero-extended to 32 bits.
- **WAIT:** the watchdog counter clears on entry and increments each cycle.
  - core_done → COMMIT.
  - Counter reaching TIMEOUT without done → invalidate the result slot, go to RESP with err 3.
  - core_done in the same cycle as the timeout: done wins.
- **COMMIT (1 cycle):** the result slot's descriptor is set to the result shape and valid=1.
  - Result shape: op 0 (nA,mA); ops 1, 2 (mA,nA); op 3 (mA,nB).
  - The result slot may equal an operand slot.
- **RESP (1 cycle):** rsp_valid=1 with rsp_err (0 after COMMIT); then IDLE.

## Timing
- **Reset values:** state IDLE; all descriptors invalid with m=n=0. cmd_ready=1; busy=0; core_start=0; rsp_valid=0; rsp_err=0; desc_wr_err=0; all core_* buses 0.
- **Reset mid-operation** (any state) returns to IDLE next edge with the table cleared. No rsp_valid is generated for the aborted command; a pending core_done arriving afterwards is ignored.
- **Latencies:**
  - Handshake edge to core_start: 2 cycles.
  - Error path: rsp_valid 2 cycles after the handshake.
  - Success path: rsp_valid 2 cycles after the core_done edge.
- core_done outside WAIT is ignored.
- cmd_ready falls the cycle after the handshake and rises the cycle after RESP, so back-to-back commands are spaced at least 3 cycles apart.
- rd_* reflect the table combinationally, including a write made on the previous edge.

## Test plan
- Write slot0=2x3 and slot1=3x2, then issue op3 A=0 B=1 res=2 → core_start with op1_addr=0, op2_addr=25, res_addr=50; after core_done, rsp_err=0 and rd(2)=2x2 valid.
- Issue op1 with slot0=2x3 and slot1=3x2 → rsp_err=2 two cycles after the handshake, core_start never asserted, slot table unchanged.
- Issue op0 on empty slot 4 → rsp_err=1; descriptor write to slot 5 with m=6 → desc_wr_err pulse and rd_valid(5)=0.
- Issue op2 with scalar 7 on slot0 2x3 and withhold core_done → core_op2_m=7; rsp_err=3 after TIMEOUT cycles in WAIT; result slot invalid.
- core_done asserted in the exact timeout cycle → rsp_err=0 and the result descriptor is committed.
- Assert rst while in WAIT → next cycle IDLE, cmd_ready=1, all slots invalid, no rsp_valid; a later core_done is ignored.
